// File: rtl/ir_nec_pkg.sv
// Shared state encoding, nominal NEC durations (in ticks) and the duration match helper.
package ir_nec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        RPT_MARK
    } necState_t;

    localparam int unsigned LEAD_MARK_TICKS  = 64;
    localparam int unsigned LEAD_SPACE_TICKS = 32;
    localparam int unsigned RPT_SPACE_TICKS  = 16;
    localparam int unsigned BIT_MARK_TICKS   = 4;
    localparam int unsigned ZERO_SPACE_TICKS = 4;
    localparam int unsigned ONE_SPACE_TICKS  = 12;
    localparam int unsigned FRAME_BITS       = 32;
    localparam int unsigned BIT_IDX_W        = 5;

    // True when |dur - nominal| <= tol, written without signed arithmetic.
    function automatic logic durMatch(input int unsigned dur,
                                      input int unsigned nominal,
                                      input int unsigned tol);
        return ((dur + tol) >= nominal) && (dur <= (nominal + tol));
    endfunction

endpackage

// File: rtl/ir_env_sync.sv
// Envelope synchronizer with polarity selection; emits single-cycle rise/fall strobes.
module ir_env_sync (
    input  logic CLK_i,
    input  logic RSTN_i,
    input  logic ENV_i,
    input  logic POL_INV_i,
    output logic envRise_c,
    output logic envFall_c
);

    logic envMeta;
    logic envSync;
    logic envPrev;
    logic rawRise;
    logic rawFall;

    always_ff @(posedge CLK_i or negedge RSTN_i) begin
        if (!RSTN_i) begin
            envMeta <= 1'b0;
            envSync <= 1'b0;
            envPrev <= 1'b0;
        end else begin
            envMeta <= ENV_i;
            envSync <= envMeta;
            envPrev <= envSync;
        end
    end

    // Edges come from the raw level, so flipping POL_INV_i never fabricates an edge.
    assign rawRise   = envSync & ~envPrev;
    assign rawFall   = ~envSync & envPrev;
    assign envRise_c = POL_INV_i ? rawFall : rawRise;
    assign envFall_c = POL_INV_i ? rawRise : rawFall;

endmodule

// File: rtl/ir_nec_rx_decoder.sv
// NEC IR frame/repeat decoder on a demodulated envelope.
// Define IR_NEC_INV_CHECK_EN to reject frames whose byte 3 is not ~CMD.
module ir_nec_rx_decoder
    import ir_nec_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1688,
    parameter int unsigned TOL      = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        CLK_i,
    input  logic        RSTN_i,
    input  logic        EN_i,
    input  logic        ENV_i,
    input  logic        POL_INV_i,
    input  logic        INT_CLR_i,
    output logic [31:0] DATA_o,
    output logic [7:0]  ADDR_o,
    output logic [7:0]  CMD_o,
    output logic        FRAME_VLD_o,
    output logic        REPEAT_o,
    output logic        ERR_o,
    output logic        BUSY_o,
    output logic        INT_o
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic                  envRise_c;
    logic                  envFall_c;
    logic                  anyEdge_c;
    logic                  tick_c;
    logic                  durSat_c;
    logic                  wrongEdge_c;
    logic                  invOk_c;
    logic                  mLead_c;
    logic                  mLeadSp_c;
    logic                  mRptSp_c;
    logic                  mMark_c;
    logic                  mZero_c;
    logic                  mOne_c;
    logic [PRE_W-1:0]      preCnt;
    logic [CNT_W-1:0]      durCnt;
    necState_t             state;
    logic [BIT_IDX_W-1:0]  bitIdx;
    logic [FRAME_BITS-1:0] shiftReg;

    ir_env_sync uEnvSync (
        .CLK_i     (CLK_i),
        .RSTN_i    (RSTN_i),
        .ENV_i     (ENV_i),
        .POL_INV_i (POL_INV_i),
        .envRise_c (envRise_c),
        .envFall_c (envFall_c)
    );

    assign anyEdge_c = envRise_c | envFall_c;
    assign tick_c    = (preCnt == PRE_W'(TICK_DIV - 1));
    assign durSat_c  = (durCnt == '1);

    assign mLead_c   = durMatch(32'(durCnt), LEAD_MARK_TICKS, TOL);
    assign mLeadSp_c = durMatch(32'(durCnt), LEAD_SPACE_TICKS, TOL);
    assign mRptSp_c  = durMatch(32'(durCnt), RPT_SPACE_TICKS, TOL);
    assign mMark_c   = durMatch(32'(durCnt), BIT_MARK_TICKS, TOL);
    assign mZero_c   = durMatch(32'(durCnt), ZERO_SPACE_TICKS, TOL);
    assign mOne_c    = durMatch(32'(durCnt), ONE_SPACE_TICKS, TOL);

    // Mark states end on a fall, space states on a rise; the opposite edge is a format error.
    assign wrongEdge_c = (state inside {LEAD_MARK, BIT_MARK, STOP_MARK, RPT_MARK}) ? envRise_c :
                         (state inside {LEAD_SPACE, BIT_SPACE})                    ? envFall_c : 1'b0;

`ifdef IR_NEC_INV_CHECK_EN
    assign invOk_c = (shiftReg[31:24] == ~shiftReg[23:16]);
`else
    assign invOk_c = 1'b1;
`endif

    assign ADDR_o = DATA_o[7:0];
    assign CMD_o  = DATA_o[23:16];

    // Tick prescaler and saturating mark/space duration counter.
    always_ff @(posedge CLK_i or negedge RSTN_i) begin
        if (!RSTN_i) begin
            preCnt <= '0;
            durCnt <= '0;
        end else if (!EN_i) begin
            preCnt <= '0;
            durCnt <= '0;
        end else begin
            preCnt <= tick_c ? '0 : preCnt + PRE_W'(1);
            if (anyEdge_c) begin
                durCnt <= '0;
            end else if (tick_c && !durSat_c) begin
                durCnt <= durCnt + CNT_W'(1);
            end
        end
    end

    // Frame FSM, shift register and registered outputs.
    always_ff @(posedge CLK_i or negedge RSTN_i) begin
        if (!RSTN_i) begin
            state       <= IDLE;
            bitIdx      <= '0;
            shiftReg    <= '0;
            DATA_o      <= '0;
            FRAME_VLD_o <= 1'b0;
            REPEAT_o    <= 1'b0;
            ERR_o       <= 1'b0;
            BUSY_o      <= 1'b0;
            INT_o       <= 1'b0;
        end else begin
            FRAME_VLD_o <= 1'b0;
            REPEAT_o    <= 1'b0;
            ERR_o       <= 1'b0;
            INT_o       <= (INT_o & ~INT_CLR_i) | FRAME_VLD_o | REPEAT_o | ERR_o;
            if (!EN_i) begin
                state  <= IDLE;
                bitIdx <= '0;
                BUSY_o <= 1'b0;
            end else if ((state != IDLE) && (durSat_c || wrongEdge_c)) begin
                ERR_o  <= 1'b1;
                state  <= IDLE;
                BUSY_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (envRise_c) begin
                            state  <= LEAD_MARK;
                            BUSY_o <= 1'b1;
                        end
                    end
                    LEAD_MARK: begin
                        if (envFall_c) begin
                            state  <= mLead_c ? LEAD_SPACE : IDLE;
                            ERR_o  <= !mLead_c;
                            BUSY_o <= mLead_c;
                        end
                    end
                    LEAD_SPACE: begin
                        if (envRise_c) begin
                            if (mLeadSp_c) begin
                                state  <= BIT_MARK;
                                bitIdx <= '0;
                            end else if (mRptSp_c) begin
                                state <= RPT_MARK;
                            end else begin
                                ERR_o  <= 1'b1;
                                state  <= IDLE;
                                BUSY_o <= 1'b0;
                            end
                        end
                    end
                    BIT_MARK: begin
                        if (envFall_c) begin
                            state  <= mMark_c ? BIT_SPACE : IDLE;
                            ERR_o  <= !mMark_c;
                            BUSY_o <= mMark_c;
                        end
                    end
                    BIT_SPACE: begin
                        if (envRise_c) begin
                            if (mZero_c || mOne_c) begin
                                shiftReg <= {mOne_c, shiftReg[FRAME_BITS-1:1]};
                                if (bitIdx == BIT_IDX_W'(FRAME_BITS - 1)) begin
                                    state <= STOP_MARK;
                                end else begin
                                    state  <= BIT_MARK;
                                    bitIdx <= bitIdx + BIT_IDX_W'(1);
                                end
                            end else begin
                                ERR_o  <= 1'b1;
                                state  <= IDLE;
                                BUSY_o <= 1'b0;
                            end
                        end
                    end
                    STOP_MARK: begin
                        if (envFall_c) begin
                            if (mMark_c && invOk_c) begin
                                FRAME_VLD_o <= 1'b1;
                                DATA_o      <= shiftReg;
                            end else begin
                                ERR_o <= 1'b1;
                            end
                            state  <= IDLE;
                            BUSY_o <= 1'b0;
                        end
                    end
                    RPT_MARK: begin
                        if (envFall_c) begin
                            REPEAT_o <= mMark_c;
                            ERR_o    <= !mMark_c;
                            state    <= IDLE;
                            BUSY_o   <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        BUSY_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ir_nec_rx_decoder.sv
// Directed bench for ir_nec_rx_decoder with an event scoreboard on the pulse outputs.
// Honours IR_NEC_INV_CHECK_EN the same way the RTL does.
module tb_ir_nec_rx_decoder;

    localparam int unsigned TD      = 4;
    localparam logic [2:0]  K_FRAME = 3'b100;
    localparam logic [2:0]  K_RPT   = 3'b010;
    localparam logic [2:0]  K_ERR   = 3'b001;

    logic        CLK_i;
    logic        RSTN_i;
    logic        EN_i;
    logic        ENV_i;
    logic        POL_INV_i;
    logic        INT_CLR_i;
    logic [31:0] DATA_o;
    logic [7:0]  ADDR_o;
    logic [7:0]  CMD_o;
    logic        FRAME_VLD_o;
    logic        REPEAT_o;
    logic        ERR_o;
    logic        BUSY_o;
    logic        INT_o;

    int          checks = 0;
    int          errors = 0;
    logic        inv    = 1'b0;
    logic [31:0] lastData = 32'h0;
    logic [2:0]  qKind[$];
    logic [31:0] qData[$];

    ir_nec_rx_decoder #(.TICK_DIV(TD), .TOL(3), .CNT_W(8)) dut (
        .CLK_i       (CLK_i),
        .RSTN_i      (RSTN_i),
        .EN_i        (EN_i),
        .ENV_i       (ENV_i),
        .POL_INV_i   (POL_INV_i),
        .INT_CLR_i   (INT_CLR_i),
        .DATA_o      (DATA_o),
        .ADDR_o      (ADDR_o),
        .CMD_o       (CMD_o),
        .FRAME_VLD_o (FRAME_VLD_o),
        .REPEAT_o    (REPEAT_o),
        .ERR_o       (ERR_o),
        .BUSY_o      (BUSY_o),
        .INT_o       (INT_o)
    );

    initial CLK_i = 1'b0;
    always #5 CLK_i = ~CLK_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic expectEvt(input logic [2:0] kind, input logic [31:0] data);
        qKind.push_back(kind);
        qData.push_back(data);
    endtask

    task automatic seg(input logic lvl, input int ticks);
        ENV_i = lvl ^ inv;
        repeat (ticks * TD) @(negedge CLK_i);
    endtask

    task automatic sendBits(input logic [31:0] data, input int nBits);
        seg(1'b1, 64);
        seg(1'b0, 32);
        for (int i = 0; i < nBits; i++) begin
            seg(1'b1, 4);
            seg(1'b0, data[i] ? 12 : 4);
        end
    endtask

    task automatic sendFrame(input logic [31:0] data);
        sendBits(data, 32);
        seg(1'b1, 4);
        ENV_i = inv;
    endtask

    task automatic sendRepeat();
        seg(1'b1, 64);
        seg(1'b0, 16);
        seg(1'b1, 4);
        ENV_i = inv;
    endtask

    task automatic pulseClr();
        INT_CLR_i = 1'b1;
        @(negedge CLK_i);
        INT_CLR_i = 1'b0;
        @(negedge CLK_i);
    endtask

    // Scoreboard: every pulse must match the oldest expected event.
    initial begin
        logic [2:0]  k;
        logic [31:0] d;
        forever begin
            @(negedge CLK_i);
            if (FRAME_VLD_o || REPEAT_o || ERR_o) begin
                if (qKind.size() == 0) begin
                    chk("unexpected_pulse", 32'({FRAME_VLD_o, REPEAT_o, ERR_o}), 32'h0);
                end else begin
                    k = qKind.pop_front();
                    d = qData.pop_front();
                    chk("pulse_kind", 32'({FRAME_VLD_o, REPEAT_o, ERR_o}), 32'(k));
                    chk("pulse_data", DATA_o, d);
                    if (k == K_FRAME) begin
                        chk("addr", 32'(ADDR_o), 32'(d[7:0]));
                        chk("cmd", 32'(CMD_o), 32'(d[23:16]));
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] badInv;
        logic        seen;
        RSTN_i    = 1'b0;
        EN_i      = 1'b1;
        ENV_i     = 1'b0;
        POL_INV_i = 1'b0;
        INT_CLR_i = 1'b0;
        repeat (5) @(negedge CLK_i);
        chk("rst_data", DATA_o, 32'h0);
        chk("rst_pulses", 32'({FRAME_VLD_o, REPEAT_o, ERR_o}), 32'h0);
        chk("rst_busy_int", 32'({BUSY_o, INT_o}), 32'h0);
        RSTN_i = 1'b1;
        seg(1'b0, 10);

        // Plain frame
        lastData = 32'hBA45FF00;
        expectEvt(K_FRAME, lastData);
        sendFrame(lastData);
        seg(1'b0, 20);
        chk("s1_data", DATA_o, 32'hBA45FF00);
        chk("s1_int", 32'(INT_o), 32'h1);
        chk("s1_busy", 32'(BUSY_o), 32'h0);

        // Repeat code keeps data
        pulseClr();
        chk("s2_int_clr", 32'(INT_o), 32'h0);
        expectEvt(K_RPT, lastData);
        sendRepeat();
        seg(1'b0, 20);
        chk("s2_int", 32'(INT_o), 32'h1);
        chk("s2_data", DATA_o, 32'hBA45FF00);

        // Bad inverse command byte
        badInv = 32'hBB45FF00;
`ifdef IR_NEC_INV_CHECK_EN
        expectEvt(K_ERR, lastData);
`else
        expectEvt(K_FRAME, badInv);
        lastData = badInv;
`endif
        sendFrame(badInv);
        seg(1'b0, 20);
        chk("s3_data", DATA_o, lastData);

        // Leader then a never-ending space: timeout at counter saturation
        expectEvt(K_ERR, lastData);
        seg(1'b1, 64);
        seg(1'b0, 100);
        chk("s4_busy_mid", 32'(BUSY_o), 32'h1);
        seg(1'b0, 200);
        chk("s4_busy_end", 32'(BUSY_o), 32'h0);

        // Bit space of 8 ticks lies outside both symbol windows
        expectEvt(K_ERR, lastData);
        sendBits(32'h0, 1);
        seg(1'b1, 4);
        seg(1'b0, 8);
        seg(1'b1, 4);
        seg(1'b0, 20);
        chk("s5_busy", 32'(BUSY_o), 32'h0);
        lastData = 32'h7F80EE11;
        expectEvt(K_FRAME, lastData);
        sendFrame(lastData);
        seg(1'b0, 20);
        chk("s5_data", DATA_o, 32'h7F80EE11);

        // Reset in the middle of bit 17
        sendBits(32'hBA45FF00, 17);
        seg(1'b1, 2);
        RSTN_i = 1'b0;
        ENV_i  = inv;
        repeat (3) @(negedge CLK_i);
        chk("s6_rst_data", DATA_o, 32'h0);
        chk("s6_rst_flags", 32'({FRAME_VLD_o, REPEAT_o, ERR_o, BUSY_o, INT_o}), 32'h0);
        RSTN_i   = 1'b1;
        lastData = 32'hBA45FF00;
        seg(1'b0, 20);
        expectEvt(K_FRAME, lastData);
        sendFrame(lastData);
        seg(1'b0, 20);
        chk("s6_data", DATA_o, 32'hBA45FF00);

        // Enable dropped mid-leader: silent abort
        seg(1'b1, 64);
        seg(1'b0, 10);
        chk("en_busy_before", 32'(BUSY_o), 32'h1);
        EN_i = 1'b0;
        repeat (2) @(negedge CLK_i);
        chk("en_busy_abort", 32'(BUSY_o), 32'h0);
        EN_i = 1'b1;
        seg(1'b0, 20);
        chk("en_idle_flags", 32'({BUSY_o, INT_o}), 32'h1);

        // Clear coinciding with the frame pulse loses to the set
        pulseClr();
        chk("s7_int_pre", 32'(INT_o), 32'h0);
        lastData = 32'hEF10AA55;
        expectEvt(K_FRAME, lastData);
        sendFrame(lastData);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK_i);
            if (FRAME_VLD_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk("s7_pulse_seen", 32'(seen), 32'h1);
        INT_CLR_i = 1'b1;
        @(negedge CLK_i);
        chk("s7_int_set_wins", 32'(INT_o), 32'h1);
        @(negedge CLK_i);
        INT_CLR_i = 1'b0;
        chk("s7_int_cleared", 32'(INT_o), 32'h0);
        seg(1'b0, 10);

        // Inverted envelope reproduces the first frame
        POL_INV_i = 1'b1;
        inv       = 1'b1;
        seg(1'b0, 20);
        lastData = 32'hBA45FF00;
        expectEvt(K_FRAME, lastData);
        sendFrame(lastData);
        seg(1'b0, 20);
        chk("s8_data", DATA_o, 32'hBA45FF00);
        chk("s8_int", 32'(INT_o), 32'h1);

        chk("queue_drained", 32'(qKind.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
